// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
// Round-robin conflict resolution is enabled with RAM_ARB_ROUND_ROBIN_EN.
package ram_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// RAM_ARB_ROUND_ROBIN_EN: conflicts alternate via last_win; otherwise data wins.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic  i_req,
  input  logic  d_req,
`ifdef RAM_ARB_ROUND_ROBIN_EN
  input  port_t last_win,
`endif
  output logic  pick_valid,
  output port_t pick
);

  always_comb begin
    pick_valid = i_req | d_req;
    pick       = PORT_D;
    if (i_req && d_req) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      pick = (last_win == PORT_D) ? PORT_I : PORT_D;
`else
      pick = PORT_D;
`endif
    end else if (i_req) begin
      pick = PORT_I;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between instruction-fetch and data ports.
// Accept in T, RAM access in T+1, registered response in T+2; RAM_ARB_ROUND_ROBIN_EN selects round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_A,
  output logic [DATA_WIDTH-1:0] ram_WD,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_RD,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  arb_state_t state;
  port_t      pick_c;
  logic       pick_valid_c;
  logic       conflict_c;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  port_t last_win;

  ram_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_win   (last_win),
    .pick_valid (pick_valid_c),
    .pick       (pick_c)
  );
`else
  ram_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .pick_valid (pick_valid_c),
    .pick       (pick_c)
  );
`endif

  // Grants are combinational so a request is accepted in the same cycle.
  assign i_gnt      = ~rst & pick_valid_c & (pick_c == PORT_I);
  assign d_gnt      = ~rst & pick_valid_c & (pick_c == PORT_D);
  assign conflict_c = i_req & d_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ram_A        <= '0;
      ram_WD       <= '0;
      ram_we       <= 1'b0;
      i_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      conflict_cnt <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      last_win     <= PORT_D;
`endif
    end else begin
      // Response stage: capture RAM data for the port served this cycle.
      i_rvalid <= (state == SERVE_I);
      d_rvalid <= (state == SERVE_D);
      if (state == SERVE_I) i_rdata <= ram_RD;
      if (state == SERVE_D) d_rdata <= ram_RD;

      // Accept stage: ram_A/ram_WD keep their last values when idle.
      ram_we <= 1'b0;
      if (i_gnt) begin
        state <= SERVE_I;
        ram_A <= i_addr;
      end else if (d_gnt) begin
        state  <= SERVE_D;
        ram_A  <= d_addr;
        ram_WD <= d_wdata;
        ram_we <= d_we;
      end else begin
        state <= IDLE;
      end

      if (conflict_c && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (conflict_c) last_win <= pick_c;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus random traffic vs a queue-based model.
// Expected conflict ordering follows RAM_ARB_ROUND_ROBIN_EN.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] ram_A;
  logic [DW-1:0] ram_WD, ram_RD;
  logic          ram_we;
  logic [15:0]   conflict_cnt;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_A(ram_A), .ram_WD(ram_WD), .ram_we(ram_we), .ram_RD(ram_RD),
    .conflict_cnt(conflict_cnt)
  );

  // Environment RAM: combinational read, write applied just after the clock edge.
  logic [DW-1:0] mem [DEPTH];
  assign ram_RD = mem[ram_A];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: accepted accesses and pending responses as timed queues.
  typedef struct { bit is_d; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int due; } acc_t;
  typedef struct { bit is_d; logic [DW-1:0] data; int due; } rsp_t;
  acc_t          acc_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_i_data, exp_d_data;
  int unsigned   exp_cnt;
  bit            last_was_d;
  bit            pend_we;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_wd;

  bit            obs_i_gnt, obs_d_gnt, obs_i_rv, obs_d_rv, obs_we;
  logic [DW-1:0] obs_i_rdata, obs_d_rdata;
  logic [AW-1:0] obs_a;
  logic [15:0]   obs_cnt;

  task automatic model_reset();
    acc_q.delete();
    rsp_q.delete();
    exp_i_data = '0;
    exp_d_data = '0;
    exp_cnt    = 0;
    last_was_d = 1'b1;
    pend_we    = 1'b0;
  endtask

  task automatic eval_cycle();
    bit   gi, gd, both, ev_i, ev_d;
    acc_t a;
    rsp_t r;
    both = i_req && d_req;
    gi = 1'b0; gd = 1'b0; ev_i = 1'b0; ev_d = 1'b0;
    if (!rst) begin
      if (both) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
        gd = !last_was_d;
`else
        gd = 1'b1;
`endif
        gi = !gd;
      end else begin
        gi = i_req;
        gd = d_req;
      end
    end
    check_eq("i_gnt", 32'(i_gnt), 32'(gi));
    check_eq("d_gnt", 32'(d_gnt), 32'(gd));

    if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
      a = acc_q.pop_front();
      check_eq("ram_we", 32'(ram_we), 32'(a.we));
      check_eq("ram_A", 32'(ram_A), 32'(a.addr));
      if (a.we) check_eq("ram_WD", ram_WD, a.wdata);
      r.is_d = a.is_d;
      r.data = ref_mem[a.addr];
      r.due  = cyc + 1;
      rsp_q.push_back(r);
      pend_we = a.we; pend_a = a.addr; pend_wd = a.wdata;
    end else begin
      check_eq("ram_we_idle", 32'(ram_we), 32'd0);
    end

    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.is_d) begin ev_d = 1'b1; exp_d_data = r.data; end
      else        begin ev_i = 1'b1; exp_i_data = r.data; end
    end
    check_eq("i_rvalid", 32'(i_rvalid), 32'(ev_i));
    check_eq("d_rvalid", 32'(d_rvalid), 32'(ev_d));
    check_eq("i_rdata", i_rdata, exp_i_data);
    check_eq("d_rdata", d_rdata, exp_d_data);
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));

    obs_i_gnt = i_gnt; obs_d_gnt = d_gnt; obs_i_rv = i_rvalid; obs_d_rv = d_rvalid;
    obs_we = ram_we; obs_a = ram_A; obs_i_rdata = i_rdata; obs_d_rdata = d_rdata;
    obs_cnt = conflict_cnt;

    if (!rst) begin
      if (both && exp_cnt < 32'hFFFF) exp_cnt++;
      if (both) last_was_d = gd;
      if (gi) begin
        a.is_d = 1'b0; a.we = 1'b0; a.addr = i_addr; a.wdata = '0; a.due = cyc + 1;
        acc_q.push_back(a);
      end
      if (gd) begin
        a.is_d = 1'b1; a.we = d_we; a.addr = d_addr; a.wdata = d_wdata; a.due = cyc + 1;
        acc_q.push_back(a);
      end
    end
    cyc++;
  endtask

  task automatic tick();
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    we = ram_we; a = ram_A; wd = ram_WD;
    @(posedge clk);
    #1;
    if (we) mem[a] = wd;
    if (pend_we && !rst) ref_mem[pend_a] = pend_wd;
    pend_we = 1'b0;
  endtask

  task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #1;
    eval_cycle();
    tick();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] old_word;
    logic [15:0]   cnt_start;
    int            we_cnt, rv_cnt, first_rv, last_rv;
    logic [DW-1:0] fetched[$];
    bit            win_d[5];
    bit            cur_ir, cur_dr, cur_dw;
    logic [AW-1:0] cur_ia, cur_da;
    logic [DW-1:0] cur_wd;

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with requests present but no grants.
    step(1'b1, 10'h001, 1'b1, 1'b1, 10'h002, 32'h1);
    check_eq("rst_ram_A", 32'(ram_A), 32'd0);
    check_eq("rst_ram_WD", ram_WD, 32'd0);
    rst = 1'b0;
    idle();

    // Single fetch with fixed latency.
    mem[4] = 32'h00500093; ref_mem[4] = 32'h00500093;
    step(1'b1, 10'h004, 1'b0, 1'b0, '0, '0);
    check_eq("fetch_gnt_T", 32'(obs_i_gnt), 32'd1);
    idle();
    check_eq("fetch_ramA_T1", 32'(obs_a), 32'd4);
    idle();
    check_eq("fetch_rvalid_T2", 32'(obs_i_rv), 32'd1);
    check_eq("fetch_rdata_T2", obs_i_rdata, 32'h00500093);

    // Store then load to the same word.
    we_cnt = 0;
    step(1'b0, '0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF); we_cnt += int'(obs_we);
    step(1'b0, '0, 1'b1, 1'b0, 10'h010, 32'h0);        we_cnt += int'(obs_we);
    idle();                                             we_cnt += int'(obs_we);
    idle();                                             we_cnt += int'(obs_we);
    check_eq("load_rvalid", 32'(obs_d_rv), 32'd1);
    check_eq("load_after_store", obs_d_rdata, 32'hDEADBEEF);
    idle();                                             we_cnt += int'(obs_we);
    check_eq("store_we_cycles", 32'(we_cnt), 32'd1);

    // Reset during SERVE_D of a store aborts the write and its acknowledge.
    old_word = ref_mem[10'h020];
    step(1'b0, '0, 1'b1, 1'b1, 10'h020, 32'hCAFEF00D);
    i_req = 1'b0; d_req = 1'b0;
    #1;
    eval_cycle();
    check_eq("abort_we_before", 32'(obs_we), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_we_drop", 32'(ram_we), 32'd0);
    model_reset();
    tick();
    step(1'b1, 10'h005, 1'b1, 1'b1, 10'h021, 32'h2);
    rst = 1'b0;
    idle();
    idle();
    check_eq("abort_ram_kept", mem[10'h020], old_word);

    // Five continuous conflicts: one priming cycle, then a four-cycle window.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, AW'(8 + k), 1'b1, 1'b0, AW'(9 + k), '0);
      win_d[k] = obs_d_gnt;
      if (k == 1) cnt_start = obs_cnt;
    end
    idle();
    check_eq("conflict_window_cnt", 32'(obs_cnt - cnt_start), 32'd4);
    check_eq("conflict_total_cnt", 32'(obs_cnt), 32'd5);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    check_eq("conflict_prime", 32'(win_d[0]), 32'd0);
    check_eq("conflict_win0", 32'(win_d[1]), 32'd1);
    check_eq("conflict_win1", 32'(win_d[2]), 32'd0);
    check_eq("conflict_win2", 32'(win_d[3]), 32'd1);
    check_eq("conflict_win3", 32'(win_d[4]), 32'd0);
`else
    check_eq("conflict_prime", 32'(win_d[0]), 32'd1);
    check_eq("conflict_win0", 32'(win_d[1]), 32'd1);
    check_eq("conflict_win1", 32'(win_d[2]), 32'd1);
    check_eq("conflict_win2", 32'(win_d[3]), 32'd1);
    check_eq("conflict_win3", 32'(win_d[4]), 32'd1);
`endif
    idle();
    idle();

    // Eight back-to-back fetches.
    for (int k = 0; k < 8; k++) begin
      mem[k] = 32'h10000000 + k; ref_mem[k] = 32'h10000000 + k;
    end
    rv_cnt = 0; first_rv = -1; last_rv = -1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) step(1'b1, AW'(k), 1'b0, 1'b0, '0, '0);
      else       idle();
      if (obs_i_rv) begin
        rv_cnt++;
        if (first_rv < 0) first_rv = k;
        last_rv = k;
        fetched.push_back(obs_i_rdata);
      end
    end
    check_eq("b2b_rvalid_count", 32'(rv_cnt), 32'd8);
    check_eq("b2b_contiguous", 32'(last_rv - first_rv), 32'd7);
    for (int k = 0; k < 8; k++)
      if (k < fetched.size()) check_eq("b2b_data", fetched[k], 32'h10000000 + k);

    // Counter saturation from 16'hFFFE.
    force dut.conflict_cnt = 16'hFFFE;
    #1;
    release dut.conflict_cnt;
    exp_cnt = 32'hFFFE;
    repeat (3) step(1'b1, 10'h030, 1'b1, 1'b0, 10'h031, '0);
    idle();
    check_eq("cnt_saturated", 32'(obs_cnt), 32'h0000FFFF);
    idle();
    idle();

    // Random traffic; a requester that was not granted holds its request.
    cur_ir = 1'b0; cur_dr = 1'b0; cur_dw = 1'b0; cur_ia = '0; cur_da = '0; cur_wd = '0;
    obs_i_gnt = 1'b0; obs_d_gnt = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!(cur_ir && !obs_i_gnt)) begin
        cur_ir = ($urandom_range(0, 99) < 60);
        cur_ia = AW'($urandom_range(0, 15));
      end
      if (!(cur_dr && !obs_d_gnt)) begin
        cur_dr = ($urandom_range(0, 99) < 60);
        cur_dw = $urandom_range(0, 1) == 1;
        cur_da = AW'($urandom_range(0, 15));
        cur_wd = $urandom;
      end
      step(cur_ir, cur_ia, cur_dr, cur_dw, cur_da, cur_wd);
    end
    repeat (4) idle();
    for (int k = 0; k < 16; k++) check_eq("final_ram", mem[k], ref_mem[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port i_req, input, 1, instruction-fetch read request.
REQ-006 SHALL have port i_addr, input, ADDR_WIDTH, fetch word address.
REQ-007 SHALL have port i_gnt, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have ports i_rvalid (output, 1) and i_rdata (output, DATA_WIDTH): fetch response.
REQ-009 SHALL have ports d_req (input, 1) and d_we (input, 1): data request, 1 = store.
REQ-010 SHALL have ports d_addr (input, ADDR_WIDTH) and d_wdata (input, DATA_WIDTH).
REQ-011 SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, DATA_WIDTH).
REQ-012 SHALL have ports ram_A (output, ADDR_WIDTH), ram_WD (output, DATA_WIDTH) and ram_we (output, 1) driving the single-port RAM.
REQ-013 SHALL have port ram_RD, input, DATA_WIDTH, combinational RAM read data.
REQ-014 SHALL have port conflict_cnt, output, 16, saturating count of cycles with both requests high.

Function
REQ-015 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-016 SHALL accept at most one request per cycle; gnt is combinational from req and arbitration state, in any state.
REQ-017 SHALL capture the winner's addr/we/wdata at the edge ending accept cycle T; next state SERVE_I or SERVE_D; with no request, next state IDLE.
REQ-018 SHALL, in cycle T+1 (SERVE_x), drive ram_A/ram_WD from captured values and set ram_we = captured d_we (SERVE_D only); ram_we = 0 in IDLE and SERVE_I.
REQ-019 SHALL register ram_RD at the end of T+1 into the winner's rdata; x_rvalid is high for exactly cycle T+2.
REQ-020 SHALL pulse d_rvalid for stores as write acknowledge; d_rdata then holds the pre-write word.
REQ-021 SHALL allow back-to-back acceptance during SERVE_x: sustained throughput one access per cycle.
REQ-022 SHALL hold i_rdata/d_rdata stable until that port's next response.
REQ-023 SHALL hold ram_A and ram_WD at their last values in IDLE.
REQ-024 SHALL, when both request: grant per REQ-030; the loser's gnt is 0 and it keeps req asserted until granted.
REQ-025 SHALL increment conflict_cnt each cycle i_req and d_req are both high, saturating at 16'hFFFF.

Reset
REQ-026 SHALL on rst force state IDLE; gnt, rvalid and ram_we 0; ram_A, ram_WD, rdata 0; conflict_cnt 0; last-winner flag = DATA.
REQ-027 SHALL abort an in-flight access when rst asserts mid-operation: no write, no rvalid afterwards.
REQ-028 SHALL assert no gnt while rst is high.

Configuration
REQ-029 SHALL support macro RAM_ARB_ROUND_ROBIN_EN.
REQ-030 SHALL, with the macro defined, grant the port that did not win the previous conflict (round-robin, one-bit last-winner flag); without it, grant the data port on conflict (fixed priority) and omit the flag.

Structure
REQ-031 SHALL place the FSM state enum, the port-ID enum (PORT_I, PORT_D) and the default width constants in package ram_arb_pkg.
REQ-032 SHALL use one sub-module, ram_arb_pick: combinational winner selection from both requests plus the last-winner flag.

Verification
REQ-033 SHALL check: i_req, i_addr=10'h004, RAM[4]=32'h00500093 -> i_gnt in T, ram_A=4 in T+1, i_rvalid in T+2 with i_rdata=32'h00500093.
REQ-034 SHALL check: store d_addr=10'h010, d_wdata=32'hDEADBEEF, then load d_addr=10'h010 -> ram_we one cycle only; load returns 32'hDEADBEEF.
REQ-035 SHALL check: both request continuously for 4 cycles -> fixed: D,D,D,D; round-robin: D,I,D,I; conflict_cnt=4.
REQ-036 SHALL check: rst asserted during SERVE_D of a store to 10'h020 -> ram_we drops immediately, RAM[0x20] unchanged, no d_rvalid.
REQ-037 SHALL check: 8 back-to-back fetches 0..7 -> 8 consecutive i_rvalid pulses, data in order.
REQ-038 SHALL check: force conflict_cnt to 16'hFFFE, then 3 conflict cycles -> conflict_cnt holds 16'hFFFF.
